// File: rtl/accel_pkg.sv
// Shared defaults and axis indices for the accelerometer moving-average filter.
package accel_pkg;

    localparam int DEF_NUM_AXES   = 3;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_LOG2_DEPTH = 2;
    localparam logic signed [DEF_DATA_W-1:0] DEF_THRESH = 16'sd256;

    localparam int AXIS_X = 0;
    localparam int AXIS_Y = 1;
    localparam int AXIS_Z = 2;

endpackage

// File: rtl/accel_axis_avg.sv
// One accelerometer axis: circular history, running sum, average/bypass select
// and saturated-magnitude threshold flag, all in one register stage.
module accel_axis_avg
    import accel_pkg::*;
#(
    parameter int                         DATA_W     = DEF_DATA_W,
    parameter int                         LOG2_DEPTH = DEF_LOG2_DEPTH,
    parameter logic signed [DATA_W-1:0]   THRESH     = DEF_THRESH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic                         clr,
    input  logic                         avg_en,
    input  logic [LOG2_DEPTH-1:0]        wr_idx,
    input  logic signed [DATA_W-1:0]     sample,
    output logic signed [DATA_W-1:0]     data,
    output logic                         over
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = DATA_W + LOG2_DEPTH;
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]        MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]        THRESH_U = THRESH;

    logic signed [DATA_W-1:0] hist_q [DEPTH];
    logic signed [DATA_W-1:0] hist_d [DEPTH];
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic signed [DATA_W-1:0] data_q, data_d;
    logic                     over_q, over_d;
    logic signed [DATA_W-1:0] oldest, sel;
    logic [DATA_W-1:0]        mag;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        hist_d = hist_q;
        sum_d  = sum_q;
        data_d = data_q;
        over_d = over_q;
        oldest = hist_q[wr_idx];
        sel    = '0;
        mag    = '0;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) hist_d[i] = '0;
            sum_d  = '0;
            data_d = '0;
            over_d = 1'b0;
        end else if (wr_en) begin
            hist_d[wr_idx] = sample;
            // Sum width covers DEPTH full-scale samples, so it can never overflow.
            sum_d = sum_q + SUM_W'(sample) - SUM_W'(oldest);
            sel   = avg_en ? DATA_W'(sum_d >>> LOG2_DEPTH) : sample;
            if (sel == MOST_NEG)  mag = MAX_POS;
            else if (sel < 0)     mag = -sel;
            else                  mag = sel;
            data_d = sel;
            over_d = (mag > THRESH_U);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: history is reset as well, because unwritten entries must read as zero in early averages.
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
            sum_q  <= '0;
            data_q <= '0;
            over_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            hist_q <= hist_d;
            sum_q  <= sum_d;
            data_q <= data_d;
            over_q <= over_d;
        end
    end

    assign data = data_q;
    assign over = over_q;

endmodule

// File: rtl/accel_axis_filter.sv
// Multi-axis accelerometer moving-average filter with bypass, clear and tilt flags.
// Shared write index, fill counter and primed flag live here; per-axis math in accel_axis_avg.
module accel_axis_filter
    import accel_pkg::*;
#(
    parameter int                         NUM_AXES   = DEF_NUM_AXES,
    parameter int                         DATA_W     = DEF_DATA_W,
    parameter int                         LOG2_DEPTH = DEF_LOG2_DEPTH,
    parameter logic signed [DATA_W-1:0]   THRESH     = DEF_THRESH
) (
    input  logic                         MAX10_CLK1_50,
    input  logic                         rst_n,
    input  logic                         s_valid,
    input  logic [NUM_AXES*DATA_W-1:0]   s_data,
    input  logic                         avg_en,
    input  logic                         clr,
    output logic                         m_valid,
    output logic [NUM_AXES*DATA_W-1:0]   m_data,
    output logic [NUM_AXES-1:0]          over,
    output logic                         primed
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int CNT_W = LOG2_DEPTH + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [LOG2_DEPTH-1:0] wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  primed_q, primed_d;
    logic                  m_valid_q, m_valid_d;
    logic                  accept;

    // A clear in the same cycle as a sample wins and drops the sample.
    assign accept = s_valid & ~clr;

    always_comb begin
        wr_idx_d  = wr_idx_q;
        cnt_d     = cnt_q;
        primed_d  = primed_q;
        m_valid_d = accept;
        if (clr) begin
            wr_idx_d = '0;
            cnt_d    = '0;
            primed_d = 1'b0;
        end else if (accept) begin
            wr_idx_d = wr_idx_q + 1'b1;
            if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
            primed_d = (cnt_d == CNT_FULL);
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q  <= '0;
            cnt_q     <= '0;
            primed_q  <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            wr_idx_q  <= wr_idx_d;
            cnt_q     <= cnt_d;
            primed_q  <= primed_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign m_valid = m_valid_q;
    assign primed  = primed_q;

    for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
        accel_axis_avg #(
            .DATA_W     (DATA_W),
            .LOG2_DEPTH (LOG2_DEPTH),
            .THRESH     (THRESH)
        ) u_axis (
            .clk    (MAX10_CLK1_50),
            .rst_n  (rst_n),
            .wr_en  (accept),
            .clr    (clr),
            .avg_en (avg_en),
            .wr_idx (wr_idx_q),
            .sample (s_data[a*DATA_W +: DATA_W]),
            .data   (m_data[a*DATA_W +: DATA_W]),
            .over   (over[a])
        );
    end

endmodule

// File: tb/tb_accel_axis_filter.sv
// Directed self-checking bench for accel_axis_filter (3 axes, 16-bit, depth 4, threshold 256).
module tb_accel_axis_filter;
    import accel_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic [47:0] s_data;
    logic        avg_en;
    logic        clr;
    logic        m_valid;
    logic [47:0] m_data;
    logic [2:0]  over;
    logic        primed;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    accel_axis_filter dut (
        .MAX10_CLK1_50 (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .avg_en        (avg_en),
        .clr           (clr),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .over          (over),
        .primed        (primed)
    );

    function automatic logic [47:0] pack3(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        return {z, y, x};
    endfunction

    // Drives one cycle of inputs starting just after a falling edge; returns at the next falling edge.
    task automatic step(input logic v, input logic [47:0] d, input logic ae, input logic c);
        s_valid = v;
        s_data  = d;
        avg_en  = ae;
        clr     = c;
        @(negedge clk);
        s_valid = 1'b0;
        clr     = 1'b0;
    endtask

    task automatic apply_reset;
        s_valid = 1'b0;
        clr     = 1'b0;
        avg_en  = 1'b1;
        s_data  = '0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
    endtask

    task automatic test_reset;
        s_valid = 1'b0; clr = 1'b0; avg_en = 1'b1; s_data = '0;
        rst_n = 1'b0;
        #2;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_checks++; if (m_data !== 48'h0) begin n_fail++; $display("FAIL reset_m_data: got %h want 0", m_data); end
        n_checks++; if (over !== 3'b000) begin n_fail++; $display("FAIL reset_over: got %b want 000", over); end
        n_checks++; if (primed !== 1'b0) begin n_fail++; $display("FAIL reset_primed: got %b want 0", primed); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_sample;
        apply_reset();
        step(1'b1, pack3(16'h0123, 16'h0456, 16'h0789), 1'b1, 1'b0);
        n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL first_m_valid: got %b want 1", m_valid); end
        n_checks++; if (m_data !== pack3(16'h0048, 16'h0115, 16'h01E2)) begin n_fail++; $display("FAIL first_m_data: got %h want %h", m_data, pack3(16'h0048, 16'h0115, 16'h01E2)); end
        n_checks++; if (primed !== 1'b0) begin n_fail++; $display("FAIL first_primed: got %b want 0", primed); end
        // y average 277 and z average 482 both exceed 256.
        n_checks++; if (over !== 3'b110) begin n_fail++; $display("FAIL first_over: got %b want 110", over); end
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL first_idle_valid: got %b want 0", m_valid); end
        n_checks++; if (m_data !== pack3(16'h0048, 16'h0115, 16'h01E2)) begin n_fail++; $display("FAIL first_idle_hold: got %h", m_data); end
    endtask

    task automatic test_back_to_back;
        int xs[5]  = '{100, 100, 100, 100, -100};
        int ex[5]  = '{25, 50, 75, 100, 50};
        logic ep[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, pack3(16'(xs[i]), 16'h0000, 16'h0000), 1'b1, 1'b0);
            n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, m_valid); end
            n_checks++; if (m_data !== pack3(16'(ex[i]), 16'h0, 16'h0)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, m_data, pack3(16'(ex[i]), 16'h0, 16'h0)); end
            n_checks++; if (primed !== ep[i]) begin n_fail++; $display("FAIL b2b_primed[%0d]: got %b want %b", i, primed, ep[i]); end
        end
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_valid: got %b want 0", m_valid); end
    endtask

    task automatic test_saturation;
        int ex[4] = '{-8192, -16384, -24576, -32768};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pack3(16'h8000, 16'h0, 16'h0), 1'b1, 1'b0);
            n_checks++; if (m_data[15:0] !== 16'(ex[i])) begin n_fail++; $display("FAIL sat_x[%0d]: got %h want %h", i, m_data[15:0], 16'(ex[i])); end
            n_checks++; if (over[AXIS_X] !== 1'b1) begin n_fail++; $display("FAIL sat_over[%0d]: got %b want 1", i, over[AXIS_X]); end
        end
        apply_reset();
        step(1'b1, pack3(16'hFFFF, 16'h0, 16'h0), 1'b1, 1'b0);
        n_checks++; if (m_data[15:0] !== 16'hFFFF) begin n_fail++; $display("FAIL floor_x: got %h want ffff", m_data[15:0]); end
        n_checks++; if (over[AXIS_X] !== 1'b0) begin n_fail++; $display("FAIL floor_over: got %b want 0", over[AXIS_X]); end
    endtask

    task automatic test_bypass;
        apply_reset();
        step(1'b1, pack3(16'h0A1B, 16'h0, 16'h0), 1'b0, 1'b0);
        n_checks++; if (m_data[15:0] !== 16'h0A1B) begin n_fail++; $display("FAIL byp_x: got %h want 0a1b", m_data[15:0]); end
        n_checks++; if (over[AXIS_X] !== 1'b1) begin n_fail++; $display("FAIL byp_over: got %b want 1", over[AXIS_X]); end
        // (2587 + 256) / 4 = 710
        step(1'b1, pack3(16'h0100, 16'h0, 16'h0), 1'b1, 1'b0);
        n_checks++; if (m_data[15:0] !== 16'h02C6) begin n_fail++; $display("FAIL byp_toggle_x: got %h want 02c6", m_data[15:0]); end
        // |-256| equals the threshold, so the flag stays low.
        step(1'b1, pack3(16'hFF00, 16'h0, 16'h0), 1'b0, 1'b0);
        n_checks++; if (m_data[15:0] !== 16'hFF00) begin n_fail++; $display("FAIL byp_neg_x: got %h want ff00", m_data[15:0]); end
        n_checks++; if (over[AXIS_X] !== 1'b0) begin n_fail++; $display("FAIL byp_thresh_eq: got %b want 0", over[AXIS_X]); end
        // 2587 + 256 - 256 + 0 = 2587 -> 646
        step(1'b1, pack3(16'h0000, 16'h0, 16'h0), 1'b1, 1'b0);
        n_checks++; if (m_data[15:0] !== 16'h0286) begin n_fail++; $display("FAIL byp_avg4_x: got %h want 0286", m_data[15:0]); end
        n_checks++; if (primed !== 1'b1) begin n_fail++; $display("FAIL byp_primed: got %b want 1", primed); end
    endtask

    task automatic test_clear;
        apply_reset();
        repeat (3) step(1'b1, pack3(16'd1000, 16'h0, 16'h0), 1'b1, 1'b0);
        n_checks++; if (m_data[15:0] !== 16'd750) begin n_fail++; $display("FAIL clr_pre_x: got %0d want 750", m_data[15:0]); end
        n_checks++; if (over[AXIS_X] !== 1'b1) begin n_fail++; $display("FAIL clr_pre_over: got %b want 1", over[AXIS_X]); end
        step(1'b1, pack3(16'd1000, 16'd1000, 16'd1000), 1'b1, 1'b1);
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b want 0", m_valid); end
        n_checks++; if (m_data !== 48'h0) begin n_fail++; $display("FAIL clr_data: got %h want 0", m_data); end
        n_checks++; if (over !== 3'b000) begin n_fail++; $display("FAIL clr_over: got %b want 000", over); end
        n_checks++; if (primed !== 1'b0) begin n_fail++; $display("FAIL clr_primed: got %b want 0", primed); end
        step(1'b1, pack3(16'd40, 16'h0, 16'h0), 1'b1, 1'b0);
        n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL clr_next_valid: got %b want 1", m_valid); end
        n_checks++; if (m_data !== pack3(16'd10, 16'h0, 16'h0)) begin n_fail++; $display("FAIL clr_next_data: got %h want %h", m_data, pack3(16'd10, 16'h0, 16'h0)); end
    endtask

    task automatic test_async_reset;
        int ex[4] = '{2, 4, 6, 8};
        logic ep[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        step(1'b1, pack3(16'd200, 16'h0, 16'h0), 1'b1, 1'b0);
        step(1'b1, pack3(16'd200, 16'h0, 16'h0), 1'b1, 1'b0);
        n_checks++; if (m_data[15:0] !== 16'd100) begin n_fail++; $display("FAIL arst_pre_x: got %0d want 100", m_data[15:0]); end
        s_valid = 1'b1;
        s_data  = pack3(16'd200, 16'h0, 16'h0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", m_valid); end
        n_checks++; if (m_data !== 48'h0) begin n_fail++; $display("FAIL arst_data: got %h want 0", m_data); end
        n_checks++; if (primed !== 1'b0) begin n_fail++; $display("FAIL arst_primed: got %b want 0", primed); end
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pack3(16'd8, 16'h0, 16'h0), 1'b1, 1'b0);
            n_checks++; if (m_data[15:0] !== 16'(ex[i])) begin n_fail++; $display("FAIL arst_post_x[%0d]: got %0d want %0d", i, m_data[15:0], ex[i]); end
            n_checks++; if (primed !== ep[i]) begin n_fail++; $display("FAIL arst_post_primed[%0d]: got %b want %b", i, primed, ep[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_back_to_back();
        test_saturation();
        test_bypass();
        test_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
